// File: rtl/mux_arb_reg.sv
// Registered N-way handshaked mux with an internal fixed-priority
// or round-robin arbiter choosing the source channel.
module mux_arb_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 6,
    parameter int SEL_WIDTH  = 3,
    parameter int ARB_MODE   = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]            in_valid,
    output logic [NUM_CH-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [SEL_WIDTH-1:0]         out_sel,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int PW = SEL_WIDTH + 1;

    logic [SEL_WIDTH-1:0]  ptr;
    logic [SEL_WIDTH-1:0]  ptr_eff;
    logic [SEL_WIDTH-1:0]  ptr_nxt;
    logic [SEL_WIDTH-1:0]  gidx;
    logic [NUM_CH-1:0]     lo_mask;
    logic [NUM_CH-1:0]     hi;
    logic [NUM_CH-1:0]     pick;
    logic [NUM_CH-1:0]     grant;
    logic                  found;
    logic                  can_accept;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] gdata;

    // Out-of-range pointers and fixed-priority mode both search from 0.
    always_comb begin
        ptr_eff = ptr;
        if (ARB_MODE == 0 || PW'(ptr) >= PW'(NUM_CH)) begin
            ptr_eff = '0;
        end
    end

    // Two-pass search: channels at/above the pointer first, then wrap.
    always_comb begin
        lo_mask = (NUM_CH'(1) << ptr_eff) - NUM_CH'(1);
        hi      = in_valid & ~lo_mask;
        pick    = (|hi) ? hi : in_valid;
        found   = 1'b0;
        gidx    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && pick[i]) begin
                found = 1'b1;
                gidx  = SEL_WIDTH'(i);
            end
        end
        grant = found ? (NUM_CH'(1) << gidx) : '0;
    end

    always_comb begin
        gdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                gdata = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign can_accept = !out_valid || out_ready;
    assign in_ready   = (rst_n && can_accept) ? grant : '0;
    assign xfer       = |(in_valid & in_ready);
    assign ptr_nxt    = (PW'(gidx) == PW'(NUM_CH - 1)) ?
                        '0 : gidx + SEL_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= gdata;
                out_sel   <= gidx;
                if (ARB_MODE != 0) begin
                    ptr <= ptr_nxt;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_arb_reg.sv
// Directed bench for mux_arb_reg: one round-robin and one
// fixed-priority instance driven by the same stimulus.
module tb_mux_arb_reg;

    logic          clk;
    logic          rst_n;
    logic [191:0]  in_data;
    logic [5:0]    in_valid;
    logic          out_ready;

    logic [5:0]    in_ready;
    logic [31:0]   out_data;
    logic [2:0]    out_sel;
    logic          out_valid;

    logic [5:0]    fp_in_ready;
    logic [31:0]   fp_out_data;
    logic [2:0]    fp_out_sel;
    logic          fp_out_valid;

    int checks = 0;
    int errors = 0;

    mux_arb_reg #(
        .DATA_WIDTH(32), .NUM_CH(6), .SEL_WIDTH(3), .ARB_MODE(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_sel(out_sel),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_arb_reg #(
        .DATA_WIDTH(32), .NUM_CH(6), .SEL_WIDTH(3), .ARB_MODE(0)
    ) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(fp_in_ready),
        .out_data(fp_out_data), .out_sel(fp_out_sel),
        .out_valid(fp_out_valid), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [31:0] v);
        in_data[ch*32 +: 32] = v;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = '0;
        out_ready = 1'b0;
        #12;
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_data", 64'(out_data), 64'(0));
        chk("rst_sel", 64'(out_sel), 64'(0));
        chk("rst_fp_valid", 64'(fp_out_valid), 64'(0));
        in_valid = 6'b111111;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        in_valid = '0;
        rst_n = 1'b1;
        tick();

        // round-robin fairness, all channels valid
        for (int i = 0; i < 6; i++) set_ch(i, 32'h100 + 32'(i));
        in_valid  = 6'b111111;
        out_ready = 1'b1;
        #1;
        chk("rr_first_ready", 64'(in_ready), 64'h01);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("rr_sel%0d", i), 64'(out_sel), 64'(i % 6));
            chk($sformatf("rr_data%0d", i), 64'(out_data),
                64'(32'h100 + 32'(i % 6)));
            chk($sformatf("rr_valid%0d", i), 64'(out_valid), 64'(1));
            chk($sformatf("fp_all_sel%0d", i), 64'(fp_out_sel), 64'(0));
        end
        in_valid = '0;
        tick();
        chk("rr_drain_valid", 64'(out_valid), 64'(0));

        // fixed priority: ch1 and ch3 valid
        in_valid = 6'b001010;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("fp_ready%0d", i), 64'(fp_in_ready), 64'h02);
            chk($sformatf("fp_ready3_%0d", i), 64'(fp_in_ready[3]), 64'(0));
            tick();
            chk($sformatf("fp_sel%0d", i), 64'(fp_out_sel), 64'(1));
            chk($sformatf("fp_valid%0d", i), 64'(fp_out_valid), 64'(1));
        end
        in_valid = '0;
        tick();

        // single channel: ch4 (RR pointer is 4 after last ch3 grant)
        set_ch(4, 32'h44);
        in_valid = 6'b010000;
        #1;
        chk("single_ready", 64'(in_ready), 64'h10);
        tick();
        in_valid = '0;
        chk("single_valid", 64'(out_valid), 64'(1));
        chk("single_data", 64'(out_data), 64'h44);
        chk("single_sel", 64'(out_sel), 64'(4));
        tick();
        chk("single_drain", 64'(out_valid), 64'(0));

        // reset mid-stall
        set_ch(2, 32'hDEADBEEF);
        in_valid  = 6'b000100;
        out_ready = 1'b0;
        tick();
        in_valid = '0;
        chk("stall_load_data", 64'(out_data), 64'hDEADBEEF);
        chk("stall_load_sel", 64'(out_sel), 64'(2));
        tick();
        chk("stall_hold_valid", 64'(out_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        in_valid = 6'b000100;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'(0));
        chk("async_rst_data", 64'(out_data), 64'(0));
        chk("async_rst_sel", 64'(out_sel), 64'(0));
        chk("async_rst_ready", 64'(in_ready), 64'(0));
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 64'(in_ready), 64'h04);
        tick();
        in_valid = '0;
        chk("post_rst_data", 64'(out_data), 64'hDEADBEEF);
        chk("post_rst_sel", 64'(out_sel), 64'(2));
        chk("post_rst_valid", 64'(out_valid), 64'(1));

        // backpressure, starting from a fresh pointer
        #1;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        set_ch(0, 32'hA0);
        set_ch(5, 32'hA5);
        in_valid = 6'b100001;
        #1;
        chk("bp_first_ready", 64'(in_ready), 64'h01);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_ready%0d", i), 64'(in_ready), 64'(0));
            chk($sformatf("bp_data%0d", i), 64'(out_data), 64'hA0);
            chk($sformatf("bp_sel%0d", i), 64'(out_sel), 64'(0));
            chk($sformatf("bp_valid%0d", i), 64'(out_valid), 64'(1));
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(in_ready), 64'h20);
        tick();
        chk("bp_sel5", 64'(out_sel), 64'(5));
        chk("bp_data5", 64'(out_data), 64'hA5);

        // drain to idle from ch3
        set_ch(3, 32'h33);
        in_valid = 6'b001000;
        tick();
        in_valid = '0;
        chk("drain_sel", 64'(out_sel), 64'(3));
        chk("drain_valid1", 64'(out_valid), 64'(1));
        tick();
        chk("drain_valid0", 64'(out_valid), 64'(0));
        chk("drain_sel_hold", 64'(out_sel), 64'(3));
        chk("drain_data_hold", 64'(out_data), 64'h33);
        tick();
        in_valid = 6'b111111;
        #1;
        chk("ptr4_ready", 64'(in_ready), 64'h10);
        tick();
        chk("ptr4_sel", 64'(out_sel), 64'(4));
        chk("ptr4_data", 64'(out_data), 64'h44);
        in_valid = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
